// File: rtl/cache_pkg.sv
// Shared types for the 2-way write-back cache controller: FSM state encoding,
// way count and address split helpers.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_RESP   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam int unsigned WAYS = 2;

  // Low idx_w bits select the set; the remaining upper bits form the tag.
  function automatic logic [31:0] split_index(input logic [31:0] adr, input int unsigned idx_w);
    return adr & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] split_tag(input logic [31:0] adr, input int unsigned idx_w);
    return adr >> idx_w;
  endfunction

endpackage

// File: rtl/cache_set_array.sv
// Tag/valid/dirty/data/LRU storage for a 2-way set-associative cache.
// Combinational read by index; one write port with per-field enables.
module cache_set_array
  import cache_pkg::*;
#(
  parameter int unsigned SETS   = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TAG_W  = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic [WAYS-1:0][TAG_W-1:0]   rd_tag,
  output logic [WAYS-1:0]              rd_valid,
  output logic [WAYS-1:0]              rd_dirty,
  output logic [WAYS-1:0][DATA_W-1:0]  rd_data,
  output logic                         rd_lru,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic                         wr_way,
  input  logic                         wr_tag_en,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic                         wr_valid_en,
  input  logic                         wr_valid,
  input  logic                         wr_dirty_en,
  input  logic                         wr_dirty,
  input  logic                         wr_data_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_lru_en,
  input  logic                         wr_lru
);

  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [DATA_W-1:0] data_mem  [SETS][WAYS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WAYS-1:0]   dirty_mem [SETS];
  logic [SETS-1:0]   lru_mem;

  for (genvar w = 0; w < WAYS; w++) begin : g_rd
    assign rd_tag[w]   = tag_mem[rd_idx][w];
    assign rd_data[w]  = data_mem[rd_idx][w];
    assign rd_valid[w] = valid_mem[rd_idx][w];
    assign rd_dirty[w] = dirty_mem[rd_idx][w];
  end
  assign rd_lru = lru_mem[rd_idx];

  // Tag and data payload carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_tag_en)  tag_mem[wr_idx][wr_way]  <= wr_tag;
    if (wr_data_en) data_mem[wr_idx][wr_way] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
      end
      lru_mem <= '0;
    end else begin
      if (wr_valid_en) valid_mem[wr_idx][wr_way] <= wr_valid;
      if (wr_dirty_en) dirty_mem[wr_idx][wr_way] <= wr_dirty;
      if (wr_lru_en)   lru_mem[wr_idx]           <= wr_lru;
    end
  end

endmodule

// File: rtl/cache_ctrl_wb.sv
// 2-way set-associative write-back, write-allocate cache controller.
// Optional CACHE_STATS_EN adds saturating hit/miss/write-back counters.
module cache_ctrl_wb
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_cpu_i,
  input  logic [ADDR_W-1:0] adr_cpu_i,
  input  logic [DATA_W-1:0] dat_cpu_i,
  input  logic              we_cpu_i,
  output logic [DATA_W-1:0] dat_cpu_o,
  output logic              ack_cpu_o,
  output logic              err_cpu_o,
  input  logic [DATA_W-1:0] dat_mem_i,
  input  logic              ack_mem_i,
  input  logic              err_mem_i,
  output logic              cyc_m2s,
  output logic              we_m2s,
  output logic [ADDR_W-1:0] adr_m2s,
  output logic [DATA_W-1:0] dat_m2s,
  output logic [2:0]        state_test
`ifdef CACHE_STATS_EN
 ,output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  state_t              state;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dat_q;
  logic                we_q;
  logic                vic_q;
  logic [IDX_W-1:0]    idx_q;
  logic [TAG_W-1:0]    tag_q;

  logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
  logic [WAYS-1:0]             rd_valid, rd_dirty;
  logic [WAYS-1:0][DATA_W-1:0] rd_data;
  logic                        rd_lru;
  logic hit0, hit1, hit, hit_way, vic;

  logic              wr_way, wr_tag_en, wr_valid_en, wr_valid, wr_dirty_en, wr_dirty;
  logic              wr_data_en, wr_lru_en, wr_lru;
  logic [DATA_W-1:0] wr_data;

  assign idx_q = IDX_W'(split_index(32'(adr_q), IDX_W));
  assign tag_q = TAG_W'(split_tag(32'(adr_q), IDX_W));

  assign hit0    = rd_valid[0] && (rd_tag[0] == tag_q);
  assign hit1    = rd_valid[1] && (rd_tag[1] == tag_q);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;
  assign vic     = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : rd_lru);

  assign state_test = state;

  cache_set_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_array (
    .clk(clk), .rst(rst),
    .rd_idx(idx_q), .rd_tag(rd_tag), .rd_valid(rd_valid), .rd_dirty(rd_dirty),
    .rd_data(rd_data), .rd_lru(rd_lru),
    .wr_idx(idx_q), .wr_way(wr_way),
    .wr_tag_en(wr_tag_en), .wr_tag(tag_q),
    .wr_valid_en(wr_valid_en), .wr_valid(wr_valid),
    .wr_dirty_en(wr_dirty_en), .wr_dirty(wr_dirty),
    .wr_data_en(wr_data_en), .wr_data(wr_data),
    .wr_lru_en(wr_lru_en), .wr_lru(wr_lru)
  );

  // Array updates happen on the same edge the FSM leaves LOOKUP/WB/FILL; errors update nothing.
  always_comb begin
    wr_way      = vic_q;
    wr_tag_en   = 1'b0;
    wr_valid_en = 1'b0;
    wr_valid    = 1'b0;
    wr_dirty_en = 1'b0;
    wr_dirty    = 1'b0;
    wr_data_en  = 1'b0;
    wr_data     = dat_q;
    wr_lru_en   = 1'b0;
    wr_lru      = 1'b0;
    case (state)
      S_LOOKUP: if (hit) begin
        wr_way      = hit_way;
        wr_lru_en   = 1'b1;
        wr_lru      = !hit_way;
        wr_data_en  = we_q;
        wr_dirty_en = we_q;
        wr_dirty    = 1'b1;
      end
      S_WB: if (ack_mem_i && !err_mem_i) begin
        wr_dirty_en = 1'b1;
      end
      S_FILL: if (ack_mem_i && !err_mem_i) begin
        wr_tag_en   = 1'b1;
        wr_valid_en = 1'b1;
        wr_valid    = 1'b1;
        wr_data_en  = 1'b1;
        wr_data     = we_q ? dat_q : dat_mem_i;
        wr_dirty_en = 1'b1;
        wr_dirty    = we_q;
        wr_lru_en   = 1'b1;
        wr_lru      = !vic_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      vic_q     <= 1'b0;
      dat_cpu_o <= '0;
      ack_cpu_o <= 1'b0;
      err_cpu_o <= 1'b0;
      cyc_m2s   <= 1'b0;
      we_m2s    <= 1'b0;
      adr_m2s   <= '0;
      dat_m2s   <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_cpu_i) begin
          adr_q <= adr_cpu_i;
          dat_q <= dat_cpu_i;
          we_q  <= we_cpu_i;
          state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (hit) begin
            ack_cpu_o <= 1'b1;
            dat_cpu_o <= we_q ? '0 : rd_data[hit_way];
            state     <= S_RESP;
          end else begin
            vic_q   <= vic;
            cyc_m2s <= 1'b1;
            if (rd_valid[vic] && rd_dirty[vic]) begin
              we_m2s  <= 1'b1;
              adr_m2s <= {rd_tag[vic], idx_q};
              dat_m2s <= rd_data[vic];
              state   <= S_WB;
            end else begin
              we_m2s  <= 1'b0;
              adr_m2s <= adr_q;
              state   <= S_FILL;
            end
          end
        end
        S_WB: begin
          if (err_mem_i) begin
            cyc_m2s   <= 1'b0;
            we_m2s    <= 1'b0;
            err_cpu_o <= 1'b1;
            state     <= S_ERR;
          end else if (ack_mem_i) begin
            we_m2s  <= 1'b0;
            adr_m2s <= adr_q;
            state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (err_mem_i) begin
            cyc_m2s   <= 1'b0;
            err_cpu_o <= 1'b1;
            state     <= S_ERR;
          end else if (ack_mem_i) begin
            cyc_m2s   <= 1'b0;
            ack_cpu_o <= 1'b1;
            dat_cpu_o <= we_q ? '0 : dat_mem_i;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          ack_cpu_o <= 1'b0;
          dat_cpu_o <= '0;
          state     <= S_IDLE;
        end
        S_ERR: begin
          err_cpu_o <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (state == S_LOOKUP && hit && hit_cnt_o != '1)   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (state == S_LOOKUP && !hit && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
      if (state == S_WB && ack_mem_i && !err_mem_i && wb_cnt_o != '1)
        wb_cnt_o <= wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Scoreboard bench for cache_ctrl_wb: expected CPU responses and memory
// transactions are queued at stimulus time and popped when the DUT produces them.
module tb_cache_ctrl_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_cpu_i;
  logic [15:0] adr_cpu_i;
  logic [31:0] dat_cpu_i;
  logic        we_cpu_i;
  logic [31:0] dat_cpu_o;
  logic        ack_cpu_o, err_cpu_o;
  logic [31:0] dat_mem_i;
  logic        ack_mem_i, err_mem_i;
  logic        cyc_m2s, we_m2s;
  logic [15:0] adr_m2s;
  logic [31:0] dat_m2s;
  logic [2:0]  state_test;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

  cache_ctrl_wb #(.ADDR_W(16), .DATA_W(32), .SETS(16)) dut (
    .clk(clk), .rst(rst),
    .req_cpu_i(req_cpu_i), .adr_cpu_i(adr_cpu_i), .dat_cpu_i(dat_cpu_i), .we_cpu_i(we_cpu_i),
    .dat_cpu_o(dat_cpu_o), .ack_cpu_o(ack_cpu_o), .err_cpu_o(err_cpu_o),
    .dat_mem_i(dat_mem_i), .ack_mem_i(ack_mem_i), .err_mem_i(err_mem_i),
    .cyc_m2s(cyc_m2s), .we_m2s(we_m2s), .adr_m2s(adr_m2s), .dat_m2s(dat_m2s),
    .state_test(state_test)
`ifdef CACHE_STATS_EN
   ,.hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic we; logic [15:0] adr; logic [31:0] dat;} mem_t;
  typedef struct packed {logic err; logic [31:0] dat;} rsp_t;

  mem_t mem_q[$];
  rsp_t cpu_q[$];
  logic [31:0] mem [logic [15:0]];
  int n_cmp = 0;
  int n_bad = 0;
  int lat = 1;
  logic err_arm = 1'b0;
  logic [15:0] err_adr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    if (a == 16'h0012) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {16'h0, a};
  endfunction

  task automatic exp_mem(input logic w, input logic [15:0] a, input logic [31:0] d);
    mem_q.push_back('{we: w, adr: a, dat: d});
  endtask

  // Memory slave: waits lat cycles with cyc_m2s high, then ends the cycle with ack or err.
  initial begin
    int cnt = 0;
    mem_t e;
    ack_mem_i = 1'b0; err_mem_i = 1'b0; dat_mem_i = '0;
    forever begin
      @(negedge clk);
      ack_mem_i = 1'b0; err_mem_i = 1'b0;
      if (rst || !cyc_m2s) cnt = 0;
      else if (cnt < lat) cnt++;
      else begin
        cnt = 0;
        if (err_arm && !we_m2s && adr_m2s == err_adr) err_mem_i = 1'b1;
        else ack_mem_i = 1'b1;
        dat_mem_i = memval(adr_m2s);
        if (ack_mem_i && we_m2s) mem[adr_m2s] = dat_m2s;
        if (mem_q.size() == 0) check("mem_unexpected", mem_q.size(), 1);
        else begin
          e = mem_q.pop_front();
          check("mem_we", {31'h0, we_m2s}, {31'h0, e.we});
          check("mem_adr", {16'h0, adr_m2s}, {16'h0, e.adr});
          if (e.we) check("mem_dat", dat_m2s, e.dat);
        end
      end
    end
  end

  // One CPU transaction; elat < 0 skips the latency check, nocyc asserts no memory activity.
  task automatic do_req(input logic [15:0] a, input logic [31:0] d, input logic w,
                        input logic [31:0] ed, input logic ee, input int elat, input logic nocyc);
    int n = 0;
    logic got = 1'b0;
    logic cyc_seen = 1'b0;
    rsp_t r;
    cpu_q.push_back('{err: ee, dat: ed});
    @(negedge clk);
    req_cpu_i = 1'b1; adr_cpu_i = a; dat_cpu_i = d; we_cpu_i = w;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (cyc_m2s) cyc_seen = 1'b1;
      if (ack_cpu_o || err_cpu_o) got = 1'b1;
    end
    check("cpu_response_seen", {31'h0, got}, 32'd1);
    if (got) begin
      r = cpu_q.pop_front();
      check("cpu_err", {31'h0, err_cpu_o}, {31'h0, r.err});
      check("cpu_ack", {31'h0, ack_cpu_o}, {31'h0, !r.err});
      if (!r.err) check("cpu_dat", dat_cpu_o, r.dat);
      if (elat >= 0) check("latency", n, elat);
      if (nocyc) check("hit_no_cyc", {31'h0, cyc_seen}, 32'd0);
    end
    req_cpu_i = 1'b0;
    @(posedge clk); #1;
    check("pulse_one_cycle", {30'h0, ack_cpu_o, err_cpu_o}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_cpu_i = 1'b0; adr_cpu_i = '0; dat_cpu_i = '0; we_cpu_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, ack_cpu_o}, 32'd0);
    check("rst_err", {31'h0, err_cpu_o}, 32'd0);
    check("rst_cyc_we", {30'h0, cyc_m2s, we_m2s}, 32'd0);
    check("rst_adr", {16'h0, adr_m2s}, 32'd0);
    check("rst_dat_m2s", dat_m2s, 32'd0);
    check("rst_dat_cpu", dat_cpu_o, 32'd0);
    check("rst_state", {29'h0, state_test}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Cold read miss then hit
    lat = 3;
    exp_mem(1'b0, 16'h0012, '0);
    do_req(16'h0012, '0, 1'b0, 32'hDEADBEEF, 1'b0, 6, 1'b0);
    do_req(16'h0012, '0, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
`ifdef CACHE_STATS_EN
    check("stat_hit", hit_cnt_o, 32'd1);
    check("stat_miss", miss_cnt_o, 32'd1);
    check("stat_wb", wb_cnt_o, 32'd0);
`endif
    do_req(16'h0012, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 2, 1'b1);
    do_req(16'h0012, '0, 1'b0, 32'hCAFEF00D, 1'b0, 2, 1'b1);

    // Write-allocate, then evict the dirty line
    lat = 1;
    exp_mem(1'b0, 16'h0003, '0);
    do_req(16'h0003, 32'h11111111, 1'b1, 32'h0, 1'b0, 4, 1'b0);
    exp_mem(1'b0, 16'h0013, '0);
    do_req(16'h0013, '0, 1'b0, 32'hC0DE0013, 1'b0, 4, 1'b0);
    exp_mem(1'b1, 16'h0003, 32'h11111111);
    exp_mem(1'b0, 16'h0023, '0);
    do_req(16'h0023, '0, 1'b0, 32'hC0DE0023, 1'b0, 6, 1'b0);
    exp_mem(1'b0, 16'h0003, '0);
    do_req(16'h0003, '0, 1'b0, 32'h11111111, 1'b0, 4, 1'b0);

    // LRU ordering with a zero-wait memory
    lat = 0;
    exp_mem(1'b0, 16'h0005, '0);
    do_req(16'h0005, '0, 1'b0, 32'hC0DE0005, 1'b0, 3, 1'b0);
    exp_mem(1'b0, 16'h0015, '0);
    do_req(16'h0015, '0, 1'b0, 32'hC0DE0015, 1'b0, 3, 1'b0);
    do_req(16'h0005, '0, 1'b0, 32'hC0DE0005, 1'b0, 2, 1'b1);
    exp_mem(1'b0, 16'h0025, '0);
    do_req(16'h0025, '0, 1'b0, 32'hC0DE0025, 1'b0, 3, 1'b0);
    do_req(16'h0005, '0, 1'b0, 32'hC0DE0005, 1'b0, 2, 1'b1);
    do_req(16'h0025, '0, 1'b0, 32'hC0DE0025, 1'b0, 2, 1'b1);
    exp_mem(1'b0, 16'h0015, '0);
    do_req(16'h0015, '0, 1'b0, 32'hC0DE0015, 1'b0, 3, 1'b0);

    // Memory error during FILL: no allocation
    lat = 1; err_adr = 16'h0040; err_arm = 1'b1;
    exp_mem(1'b0, 16'h0040, '0);
    do_req(16'h0040, '0, 1'b0, 32'h0, 1'b1, 4, 1'b0);
    err_arm = 1'b0;
    exp_mem(1'b0, 16'h0040, '0);
    do_req(16'h0040, '0, 1'b0, 32'hC0DE0040, 1'b0, 4, 1'b0);

    // Reset while a write-back is in flight
    exp_mem(1'b0, 16'h0007, '0);
    do_req(16'h0007, 32'h77777777, 1'b1, 32'h0, 1'b0, 4, 1'b0);
    exp_mem(1'b0, 16'h0017, '0);
    do_req(16'h0017, 32'h17171717, 1'b1, 32'h0, 1'b0, 4, 1'b0);
    lat = 10;
    @(negedge clk);
    req_cpu_i = 1'b1; adr_cpu_i = 16'h0027; dat_cpu_i = '0; we_cpu_i = 1'b0;
    n = 0;
    while (!(cyc_m2s && we_m2s) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("wb_started", {30'h0, cyc_m2s, we_m2s}, 32'd3);
    check("wb_adr", {16'h0, adr_m2s}, 32'h0007);
    check("wb_dat", dat_m2s, 32'h77777777);
    @(negedge clk); rst = 1'b1; req_cpu_i = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_cyc", {31'h0, cyc_m2s}, 32'd0);
    check("rst_mid_state", {29'h0, state_test}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_mid_no_rsp", {30'h0, ack_cpu_o, err_cpu_o}, 32'd0);
    end
    lat = 2;
    exp_mem(1'b0, 16'h0007, '0);
    do_req(16'h0007, '0, 1'b0, 32'hC0DE0007, 1'b0, 5, 1'b0);
    exp_mem(1'b0, 16'h0005, '0);
    do_req(16'h0005, '0, 1'b0, 32'hC0DE0005, 1'b0, 5, 1'b0);
    exp_mem(1'b0, 16'h0012, '0);
    do_req(16'h0012, '0, 1'b0, 32'hDEADBEEF, 1'b0, 5, 1'b0);

    repeat (3) @(posedge clk);
    check("mem_q_drained", mem_q.size(), 32'd0);
    check("cpu_q_drained", cpu_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
